alu_serial_core_p: RTL and testbench

- Parametrised serial-in/serial-out ALU core. Next generation of the team's fixed 32-bit serial ALU.
- Receives 2*N_BYTES operand frames and one control frame on `sin`, checks framing, CRC and opcode, and executes the operation.
- Returns N_BYTES result frames plus a control frame on `sout`, or a single error frame instead.
- Sits between the serial link pins and the test harness. Operand width scales with N_BYTES.

---
 rtl/alu_serial_core_p.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_alu_serial_core_p.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_core_p.sv
// alu_serial_core_p: serial-in/serial-out ALU core with a parametrised operand width.
// Each 11-bit frame is: start 0, type bit, 8 payload bits MSB first, stop 1.
// A request is 2*N_BYTES DATA frames (B then A) followed by one CTL frame carrying the op and a CRC4.
// The reply is N_BYTES result frames plus a CTL frame with flags and a CRC3, or a single error frame.
// Optional macro ALU_XOR_OP_EN: when defined, opcode 3'b010 performs XOR;
// when undefined, 3'b010 is an unused opcode.
module alu_serial_core_p #(
    parameter int N_BYTES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    output logic sout,
    output logic busy,
    output logic pkt_done
);
    localparam int W  = 8 * N_BYTES;
    localparam int DW = 2 * W;
    localparam logic [4:0] DATA_FULL = 5'(2 * N_BYTES);
    localparam logic [4:0] DATA_MAX  = 5'(2 * N_BYTES + 1);
    localparam logic [3:0] LAST_IDX  = 4'(N_BYTES);

    typedef enum logic [2:0] {RX_IDLE, RX_TYPE, RX_PAYLOAD, RX_STOP, RX_SKIP, RX_WAIT_HI} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t rx_state_reg, rx_next;
    tx_state_t tx_state_reg, tx_next;

    logic [3:0]    bit_cnt_reg;
    logic          type_reg;
    logic [7:0]    pay_reg;
    logic [DW-1:0] opnd_reg;
    logic [4:0]    data_cnt_reg;
    logic          ferr_reg;
    logic [W-1:0]  res_c_reg;
    logic [7:0]    resp_pay_reg;
    logic          resp_err_reg;
    logic          eval_valid_reg, eval_valid_d_reg;

    logic sout_reg, busy_reg, pkt_done_reg;
    logic [9:0] shift_reg;
    logic [3:0] tbit_reg, frame_idx_reg;

    // receiver strobes
    logic bit_clr, bit_inc, cap_type, shift_pay, data_push, ctl_eval, ferr_set;

    assign sout     = sout_reg;
    assign busy     = busy_reg;
    assign pkt_done = pkt_done_reg;

    // CRC4, polynomial x^4+x+1, zero init, message MSB first
    function automatic logic [3:0] crc4_fn(input logic [DW+3:0] m);
        logic [3:0] c;
        logic fb;
        c = 4'd0;
        for (int i = DW + 3; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // CRC3, polynomial x^3+x+1, zero init, message MSB first
    function automatic logic [2:0] crc3_fn(input logic [W+4:0] m);
        logic [2:0] c;
        logic fb;
        c = 3'd0;
        for (int i = W + 4; i >= 0; i--) begin
            fb = c[2] ^ m[i];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction

    // ---------------- packet evaluation ----------------
    logic [W-1:0] b_op, a_op, alu_c;
    logic [W:0]   sum, diff;
    logic         carry, ovf, op_ok, d_err, c_err, o_err;
    logic [3:0]   flags;
    logic [7:0]   err_pay;

    assign b_op = opnd_reg[DW-1:W];
    assign a_op = opnd_reg[W-1:0];
    assign sum  = {1'b0, b_op} + {1'b0, a_op};
    assign diff = {1'b0, b_op} - {1'b0, a_op};

    // ALU result and flags for the opcode held in the CTL payload
    always_comb begin
        alu_c = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        op_ok = 1'b1;
        case (pay_reg[6:4])
            3'b000: alu_c = b_op & a_op;
            3'b001: alu_c = b_op | a_op;
            3'b100: begin
                alu_c = sum[W-1:0];
                carry = sum[W];
                ovf   = (b_op[W-1] == a_op[W-1]) && (alu_c[W-1] != b_op[W-1]);
            end
            3'b101: begin
                alu_c = diff[W-1:0];
                carry = diff[W];
                ovf   = (b_op[W-1] != a_op[W-1]) && (alu_c[W-1] != b_op[W-1]);
            end
`ifdef ALU_XOR_OP_EN
            3'b010: alu_c = b_op ^ a_op;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    // only the highest-priority error is reported: data > crc > op
    assign flags   = {carry, ovf, (alu_c == '0), alu_c[W-1]};
    assign d_err   = (data_cnt_reg != DATA_FULL) | ferr_reg;
    assign c_err   = ~d_err & (crc4_fn({b_op, a_op, 1'b1, pay_reg[6:4]}) != pay_reg[3:0]);
    assign o_err   = ~d_err & ~c_err & ~op_ok;
    assign err_pay = {1'b1, d_err, c_err, o_err, d_err, c_err, o_err,
                      ^{1'b1, d_err, c_err, o_err, d_err, c_err, o_err}};

    // ---------------- receiver ----------------
    // receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_reg <= RX_IDLE;
        else        rx_state_reg <= rx_next;
    end

    // receiver next-state and datapath strobes; frames arriving while replying are skipped
    always_comb begin
        rx_next   = rx_state_reg;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        cap_type  = 1'b0;
        shift_pay = 1'b0;
        data_push = 1'b0;
        ctl_eval  = 1'b0;
        ferr_set  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: if (!sin) begin
                bit_clr = 1'b1;
                rx_next = busy_reg ? RX_SKIP : RX_TYPE;
            end
            RX_TYPE: begin
                cap_type = 1'b1;
                bit_clr  = 1'b1;
                rx_next  = RX_PAYLOAD;
            end
            RX_PAYLOAD: begin
                shift_pay = 1'b1;
                bit_inc   = 1'b1;
                if (bit_cnt_reg == 4'd7) rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (!sin) begin
                    ferr_set = 1'b1;
                    rx_next  = RX_WAIT_HI;
                end else begin
                    data_push = ~type_reg;
                    ctl_eval  = type_reg;
                    rx_next   = RX_IDLE;
                end
            end
            RX_SKIP: begin
                bit_inc = 1'b1;
                if (bit_cnt_reg == 4'd9) rx_next = RX_IDLE;
            end
            RX_WAIT_HI: if (sin) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    // receiver datapath, packet reset and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg      <= '0;
            type_reg         <= 1'b0;
            pay_reg          <= '0;
            opnd_reg         <= '0;
            data_cnt_reg     <= '0;
            ferr_reg         <= 1'b0;
            res_c_reg        <= '0;
            resp_pay_reg     <= '0;
            resp_err_reg     <= 1'b0;
            eval_valid_reg   <= 1'b0;
            eval_valid_d_reg <= 1'b0;
        end else begin
            eval_valid_reg   <= ctl_eval;
            eval_valid_d_reg <= eval_valid_reg;
            if (bit_clr)   bit_cnt_reg <= '0;
            else if (bit_inc) bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (cap_type)  type_reg <= sin;
            if (shift_pay) pay_reg <= {pay_reg[6:0], sin};
            if (ferr_set)  ferr_reg <= 1'b1;
            if (data_push) begin
                opnd_reg <= {opnd_reg[DW-9:0], pay_reg};
                if (data_cnt_reg != DATA_MAX) data_cnt_reg <= data_cnt_reg + 5'd1;
            end
            if (ctl_eval) begin
                res_c_reg    <= alu_c;
                resp_err_reg <= d_err | c_err | o_err;
                resp_pay_reg <= (d_err | c_err | o_err) ? err_pay
                              : {1'b0, flags, crc3_fn({alu_c, 1'b0, flags})};
                opnd_reg     <= '0;
                data_cnt_reg <= '0;
                ferr_reg     <= 1'b0;
            end
        end
    end

    // ---------------- transmitter ----------------
    // result bytes indexed LSB byte first; unused slots read as zero
    logic [7:0] c_bytes [8];
    for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
        if (gi < N_BYTES) begin : g_used
            assign c_bytes[gi] = res_c_reg[8*gi +: 8];
        end else begin : g_pad
            assign c_bytes[gi] = 8'h00;
        end
    end

    logic [3:0]  load_idx;
    logic [2:0]  byte_sel;
    logic [10:0] load_frame;
    logic        last_frame;
    logic        sout_next, busy_next, pkt_done_next;
    logic [9:0]  shift_next;
    logic [3:0]  tbit_next, frame_idx_next;

    assign load_idx   = (tx_state_reg == TX_IDLE) ? 4'd0 : frame_idx_reg + 4'd1;
    assign byte_sel   = 3'(N_BYTES - 1) - load_idx[2:0];
    assign load_frame = (resp_err_reg || load_idx == LAST_IDX)
                        ? {2'b01, resp_pay_reg, 1'b1}
                        : {2'b00, c_bytes[byte_sel], 1'b1};
    assign last_frame = resp_err_reg || (frame_idx_reg == LAST_IDX);

    // transmitter state register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg  <= TX_IDLE;
            sout_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            pkt_done_reg  <= 1'b0;
            shift_reg     <= '0;
            tbit_reg      <= '0;
            frame_idx_reg <= '0;
        end else begin
            tx_state_reg  <= tx_next;
            sout_reg      <= sout_next;
            busy_reg      <= busy_next;
            pkt_done_reg  <= pkt_done_next;
            shift_reg     <= shift_next;
            tbit_reg      <= tbit_next;
            frame_idx_reg <= frame_idx_next;
        end
    end

    // transmitter next-state: frames go out back-to-back, pkt_done marks the final stop bit
    always_comb begin
        tx_next        = tx_state_reg;
        sout_next      = sout_reg;
        busy_next      = busy_reg;
        pkt_done_next  = 1'b0;
        shift_next     = shift_reg;
        tbit_next      = tbit_reg;
        frame_idx_next = frame_idx_reg;
        case (tx_state_reg)
            TX_IDLE: if (eval_valid_d_reg) begin
                tx_next        = TX_SEND;
                sout_next      = load_frame[10];
                shift_next     = load_frame[9:0];
                tbit_next      = 4'd0;
                frame_idx_next = 4'd0;
                busy_next      = 1'b1;
            end
            TX_SEND: begin
                if (tbit_reg != 4'd10) begin
                    sout_next     = shift_reg[9];
                    shift_next    = {shift_reg[8:0], 1'b0};
                    tbit_next     = tbit_reg + 4'd1;
                    pkt_done_next = (tbit_reg == 4'd9) && last_frame;
                end else if (last_frame) begin
                    tx_next   = TX_IDLE;
                    sout_next = 1'b1;
                    busy_next = 1'b0;
                end else begin
                    sout_next      = load_frame[10];
                    shift_next     = load_frame[9:0];
                    tbit_next      = 4'd0;
                    frame_idx_next = load_idx;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_serial_core_p.sv
// Directed bench for alu_serial_core_p: three instances (N_BYTES = 4, 1, 8) share clock and reset.
module tb_alu_serial_core_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin4 = 1'b1, sin1 = 1'b1, sin8 = 1'b1;
    logic sout4, busy4, pd4, sout1, busy1, pd1, sout8, busy8, pd8;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_serial_core_p #(.N_BYTES(4)) u4 (.clk(clk), .rst_n(rst_n), .sin(sin4),
        .sout(sout4), .busy(busy4), .pkt_done(pd4));
    alu_serial_core_p #(.N_BYTES(1)) u1 (.clk(clk), .rst_n(rst_n), .sin(sin1),
        .sout(sout1), .busy(busy1), .pkt_done(pd1));
    alu_serial_core_p #(.N_BYTES(8)) u8 (.clk(clk), .rst_n(rst_n), .sin(sin8),
        .sout(sout8), .busy(busy8), .pkt_done(pd8));

    typedef struct {
        string       name;
        logic [63:0] b, a;
        logic [2:0]  op;
        logic [3:0]  crc_xor;
        int          ndata;
        int          bad_stop;
        logic        err;
        logic [63:0] exp_c;
        logic [3:0]  exp_flags;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic get_sout(input int d);
        return (d == 1) ? sout1 : (d == 8) ? sout8 : sout4;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 1) ? busy1 : (d == 8) ? busy8 : busy4;
    endfunction
    function automatic logic get_pd(input int d);
        return (d == 1) ? pd1 : (d == 8) ? pd8 : pd4;
    endfunction

    // polynomial long division remainder of msg * x^k by poly (k+1 bits)
    function automatic logic [3:0] poly_rem(input bit msg[$], input int k, input logic [4:0] poly);
        bit m[$];
        logic [3:0] r;
        m = msg;
        for (int i = 0; i < k; i++) m.push_back(1'b0);
        for (int i = 0; i < m.size() - k; i++)
            if (m[i]) for (int j = 0; j <= k; j++) m[i+j] = m[i+j] ^ poly[k-j];
        r = 4'd0;
        for (int j = 0; j < k; j++) r[k-1-j] = m[m.size()-k+j];
        return r;
    endfunction

    function automatic logic [3:0] model_crc4(input int nb, input logic [63:0] b, a, input logic [2:0] op);
        bit m[$];
        for (int i = 8*nb-1; i >= 0; i--) m.push_back(b[i]);
        for (int i = 8*nb-1; i >= 0; i--) m.push_back(a[i]);
        m.push_back(1'b1);
        for (int i = 2; i >= 0; i--) m.push_back(op[i]);
        return poly_rem(m, 4, 5'b10011);
    endfunction

    function automatic logic [2:0] model_crc3(input int nb, input logic [63:0] c, input logic [3:0] f);
        bit m[$];
        logic [3:0] r;
        for (int i = 8*nb-1; i >= 0; i--) m.push_back(c[i]);
        m.push_back(1'b0);
        for (int i = 3; i >= 0; i--) m.push_back(f[i]);
        r = poly_rem(m, 3, 5'b01011);
        return r[2:0];
    endfunction

    task automatic send_bit(input int d, input logic v);
        @(negedge clk);
        if (d == 1) sin1 = v;
        else if (d == 8) sin8 = v;
        else sin4 = v;
    endtask

    task automatic send_frame(input int d, input logic typ, input logic [7:0] pay, input logic stop);
        send_bit(d, 1'b0);
        send_bit(d, typ);
        for (int i = 7; i >= 0; i--) send_bit(d, pay[i]);
        send_bit(d, stop);
    endtask

    task automatic send_packet(input int d, input int nb, input logic [63:0] b, a, input logic [2:0] op,
                               input logic [3:0] crc_xor, input int ndata, input int bad_stop);
        logic [7:0] byt;
        logic [3:0] crc;
        for (int i = 0; i < ndata; i++) begin
            if (i < nb) byt = b[8*(nb-1-i) +: 8];
            else if (i < 2*nb) byt = a[8*(2*nb-1-i) +: 8];
            else byt = 8'h00;
            send_frame(d, 1'b0, byt, (i == bad_stop) ? 1'b0 : 1'b1);
            if (i == bad_stop) begin
                send_bit(d, 1'b1);
                send_bit(d, 1'b1);
            end
        end
        crc = model_crc4(nb, b, a, op) ^ crc_xor;
        send_frame(d, 1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    // collect one response; checks latency, framing, busy and pkt_done along the way
    task automatic get_resp(input int d, input int nb, input string tag,
                            output logic [63:0] c, output logic [7:0] ctl, output int nfr);
        int n;
        int bad;
        logic found, done, first;
        logic [10:0] fr;
        c = '0; ctl = '0; nfr = 0; found = 1'b0; bad = 0;
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (get_sout(d) == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, ".latency"}, 64'(n), 64'd3);
        if (!found) return;
        done = 1'b0;
        first = 1'b1;
        while (!done && nfr < nb + 2) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            fr[10] = get_sout(d);
            if (!get_busy(d) || get_pd(d)) bad++;
            for (int k = 9; k >= 0; k--) begin
                @(negedge clk);
                fr[k] = get_sout(d);
                if (!get_busy(d)) bad++;
                if (get_pd(d) !== ((k == 0) && fr[9])) bad++;
            end
            if (fr[10] !== 1'b0 || fr[0] !== 1'b1) bad++;
            nfr++;
            if (fr[9]) begin
                done = 1'b1;
                ctl = fr[8:1];
            end else begin
                c = {c[55:0], fr[8:1]};
            end
        end
        @(negedge clk);
        if (get_sout(d) !== 1'b1 || get_busy(d) !== 1'b0 || get_pd(d) !== 1'b0) bad++;
        check({tag, ".frame_struct"}, 64'(bad), 64'd0);
    endtask

    task automatic expect_ok(input int d, input int nb, input string tag, input logic [63:0] exp_c,
                             input logic [3:0] exp_f);
        logic [63:0] c;
        logic [7:0] ctl;
        int nfr;
        get_resp(d, nb, tag, c, ctl, nfr);
        check({tag, ".nframes"}, 64'(nfr), 64'(nb + 1));
        check({tag, ".c"}, c, exp_c);
        check({tag, ".ctl"}, {56'd0, ctl}, {56'd0, 1'b0, exp_f, model_crc3(nb, exp_c, exp_f)});
    endtask

    task automatic expect_err(input int d, input int nb, input string tag, input logic [7:0] exp_e);
        logic [63:0] c;
        logic [7:0] ctl;
        int nfr;
        get_resp(d, nb, tag, c, ctl, nfr);
        check({tag, ".nframes"}, 64'(nfr), 64'd1);
        check({tag, ".errpay"}, {56'd0, ctl}, {56'd0, exp_e});
    endtask

    // reset during the reply, then a fresh ADD packet must complete
    task automatic reset_mid(input int d, input int nb, input logic [63:0] b, a, exp_c, input logic [3:0] exp_f);
        logic found;
        string tag;
        tag = $sformatf("rst_n%0d", nb);
        found = 1'b0;
        send_packet(d, nb, 64'h3, 64'h2, 3'b100, 4'h0, 2*nb, -1);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (get_sout(d) == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, ".start_seen"}, {63'd0, found}, 64'd1);
        repeat ((nb >= 3) ? 24 : 5) @(negedge clk);
        check({tag, ".busy_before"}, {63'd0, get_busy(d)}, 64'd1);
        #1 rst_n = 1'b0;
        #1 check({tag, ".during"}, {61'd0, get_sout(d), get_busy(d), get_pd(d)}, 64'b100);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check({tag, ".after"}, {61'd0, get_sout(d), get_busy(d), get_pd(d)}, 64'b100);
        send_packet(d, nb, b, a, 3'b100, 4'h0, 2*nb, -1);
        expect_ok(d, nb, {tag, ".fresh"}, exp_c, exp_f);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{"add_small", 64'h3, 64'h2, 3'b100, 4'h0, 8, -1, 1'b0, 64'h5, 4'b0000, 8'h00});
        vecs.push_back(vec_t'{"add_ovf", 64'h7FFFFFFF, 64'h1, 3'b100, 4'h0, 8, -1, 1'b0, 64'h80000000, 4'b0101, 8'h00});
        vecs.push_back(vec_t'{"sub_neg", 64'h1, 64'h2, 3'b101, 4'h0, 8, -1, 1'b0, 64'hFFFFFFFF, 4'b1001, 8'h00});
        vecs.push_back(vec_t'{"and", 64'hF0F0F0F0, 64'hFFFF0000, 3'b000, 4'h0, 8, -1, 1'b0, 64'hF0F00000, 4'b0001, 8'h00});
        vecs.push_back(vec_t'{"or", 64'h12340000, 64'h00005678, 3'b001, 4'h0, 8, -1, 1'b0, 64'h12345678, 4'b0000, 8'h00});
        vecs.push_back(vec_t'{"add_carry", 64'hFFFFFFFF, 64'h1, 3'b100, 4'h0, 8, -1, 1'b0, 64'h0, 4'b1010, 8'h00});
        vecs.push_back(vec_t'{"sub_ovf", 64'h80000000, 64'h1, 3'b101, 4'h0, 8, -1, 1'b0, 64'h7FFFFFFF, 4'b0100, 8'h00});
        vecs.push_back(vec_t'{"sub_zero", 64'h5, 64'h5, 3'b101, 4'h0, 8, -1, 1'b0, 64'h0, 4'b0010, 8'h00});
        vecs.push_back(vec_t'{"and_zero", 64'hAAAAAAAA, 64'h55555555, 3'b000, 4'h0, 8, -1, 1'b0, 64'h0, 4'b0010, 8'h00});
        vecs.push_back(vec_t'{"short7", 64'h3, 64'h2, 3'b100, 4'h0, 7, -1, 1'b1, 64'h0, 4'b0000, 8'hC9});
        vecs.push_back(vec_t'{"long9", 64'h3, 64'h2, 3'b100, 4'h0, 9, -1, 1'b1, 64'h0, 4'b0000, 8'hC9});
        vecs.push_back(vec_t'{"short7_badcrc", 64'h3, 64'h2, 3'b100, 4'h1, 7, -1, 1'b1, 64'h0, 4'b0000, 8'hC9});
        vecs.push_back(vec_t'{"bad_stop", 64'h3, 64'h2, 3'b100, 4'h0, 8, 1, 1'b1, 64'h0, 4'b0000, 8'hC9});
        vecs.push_back(vec_t'{"crc_bad", 64'h3, 64'h2, 3'b100, 4'h1, 8, -1, 1'b1, 64'h0, 4'b0000, 8'hA5});
        vecs.push_back(vec_t'{"crc_bad_op_bad", 64'h3, 64'h2, 3'b110, 4'h1, 8, -1, 1'b1, 64'h0, 4'b0000, 8'hA5});
        vecs.push_back(vec_t'{"op110", 64'h3, 64'h2, 3'b110, 4'h0, 8, -1, 1'b1, 64'h0, 4'b0000, 8'h93});
        vecs.push_back(vec_t'{"op111", 64'h3, 64'h2, 3'b111, 4'h0, 8, -1, 1'b1, 64'h0, 4'b0000, 8'h93});
        vecs.push_back(vec_t'{"op011", 64'h3, 64'h2, 3'b011, 4'h0, 8, -1, 1'b1, 64'h0, 4'b0000, 8'h93});
`ifdef ALU_XOR_OP_EN
        vecs.push_back(vec_t'{"xor", 64'hF0F0F0F0, 64'hFFFF0000, 3'b010, 4'h0, 8, -1, 1'b0, 64'h0F0FF0F0, 4'b0000, 8'h00});
`else
        vecs.push_back(vec_t'{"xor_disabled", 64'hF0F0F0F0, 64'hFFFF0000, 3'b010, 4'h0, 8, -1, 1'b1, 64'h0, 4'b0000, 8'h93});
`endif
        vecs.push_back(vec_t'{"recover_add", 64'h3, 64'h2, 3'b100, 4'h0, 8, -1, 1'b0, 64'h5, 4'b0000, 8'h00});

        // reset state
        repeat (3) @(negedge clk);
        check("reset.n4", {61'd0, sout4, busy4, pd4}, 64'b100);
        check("reset.n1", {61'd0, sout1, busy1, pd1}, 64'b100);
        check("reset.n8", {61'd0, sout8, busy8, pd8}, 64'b100);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset.n4", {61'd0, sout4, busy4, pd4}, 64'b100);

        // table-driven vectors on the 32-bit instance
        foreach (vecs[i]) begin
            send_packet(4, 4, vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].crc_xor, vecs[i].ndata, vecs[i].bad_stop);
            if (vecs[i].err) expect_err(4, 4, vecs[i].name, vecs[i].exp_err);
            else expect_ok(4, 4, vecs[i].name, vecs[i].exp_c, vecs[i].exp_flags);
        end

        // other widths
        send_packet(1, 1, 64'h03, 64'h05, 3'b101, 4'h0, 2, -1);
        expect_ok(1, 1, "n1_sub", 64'hFE, 4'b1001);
        send_packet(1, 1, 64'h03, 64'h05, 3'b100, 4'h0, 1, -1);
        expect_err(1, 1, "n1_short", 8'hC9);
        send_packet(8, 8, 64'h7FFFFFFFFFFFFFFF, 64'h1, 3'b100, 4'h0, 16, -1);
        expect_ok(8, 8, "n8_add_ovf", 64'h8000000000000000, 4'b0101);

        // reset in the middle of a reply
        reset_mid(4, 4, 64'h3, 64'h2, 64'h5, 4'b0000);
        reset_mid(1, 1, 64'h7F, 64'h01, 64'h80, 4'b0101);
        reset_mid(8, 8, 64'h0123456789ABCDEF, 64'h1111111111111111, 64'h123456789ABCDF00, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
